// File: rtl/rv32i_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_dmem_ctrl -- RV32I data-memory controller with programmable wait states
//
// Single-port word memory behind a three-state FSM (IDLE -> WAIT -> RESP).
// An access is accepted in IDLE.
// The payload is captured at acceptance.
// WAIT lasts WAIT_CYCLES cycles; WAIT is skipped when WAIT_CYCLES is 0.
// The write is committed, or the read data is registered, on the edge that
// enters RESP.
// RESP raises done for one cycle.
//
// Parameters
//   DEPTH_WORDS  memory depth in 32-bit words (power of two, 16..65536)
//   WAIT_CYCLES  wait states per access (0..15)
//
// Ports
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   req     access request, held with stable payload until done
//   we      1 = store, 0 = load
//   addr    byte address; bits above the memory size are ignored (wrap)
//   wdata   store data, low-order bytes used
//   funct3  RV32I width/sign code
//   busy    high in WAIT and RESP
//   done    one-cycle completion pulse
//   rdata   load result, valid with done
//           stores and faulting accesses return 0
//   err     illegal funct3 (or misalignment, see below), valid with done
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                          complete with err=1 and no side effect.
//                          When undefined, those addresses are aligned down
//                          and the access completes normally.
//
// Memory contents are not affected by reset.
// ---------------------------------------------------------------------------
module rv32i_dmem_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic           accept, commit;

   logic           cap_we;
   logic [31:0]    cap_addr, cap_wdata;
   logic [2:0]     cap_f3;

   logic           op_we;
   logic [31:0]    op_addr, op_wdata;
   logic [2:0]     op_f3;

   logic           legal, fault;
   logic [1:0]     off;
   logic [AW-1:0]  idx;
   logic [31:0]    word, ld_data, st_data;
   logic [3:0]     st_mask;
   logic [7:0]     ld_b;
   logic [15:0]    ld_h;
   logic           unused_addr_hi;

   logic [31:0]    mem [DEPTH_WORDS];

   // ---------------- control ----------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: if (req) begin
            accept  = 1'b1;
            cnt_nxt = 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
               // zero-wait: commit on the accept edge using the live payload
               commit    = 1'b1;
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
            if (cnt <= 4'd1) begin
               commit    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done decode straight from state so an async reset clears them at once
   assign busy = (state != IDLE);
   assign done = (state == RESP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rdata     <= 32'd0;
         err       <= 1'b0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
         cap_f3    <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_f3    <= funct3;
         end
         if (commit) begin
            err   <= fault;
            rdata <= (fault || op_we) ? 32'd0 : ld_data;
         end
      end
   end

   // ---------------- datapath ----------------
   // The live payload is only ever consumed on a zero-wait accept.
   // Every other commit uses the captured copy, so later payload changes
   // cannot disturb the access in flight.
   assign op_we    = (state == IDLE) ? we     : cap_we;
   assign op_addr  = (state == IDLE) ? addr   : cap_addr;
   assign op_wdata = (state == IDLE) ? wdata  : cap_wdata;
   assign op_f3    = (state == IDLE) ? funct3 : cap_f3;

   assign idx            = op_addr[AW+1:2];
   assign unused_addr_hi = ^op_addr[31:AW+2];
   assign word           = mem[idx];

   always_comb begin
      legal = op_we ? (op_f3 inside {3'b000, 3'b001, 3'b010})
                    : (op_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_TRAP_EN
      off   = op_addr[1:0];
      fault = !legal
            || (op_f3[1:0] == 2'b01 && op_addr[0])
            || (op_f3[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
`else
      fault = !legal;
      case (op_f3[1:0])
         2'b01:   off = {op_addr[1], 1'b0};
         2'b10:   off = 2'b00;
         default: off = op_addr[1:0];
      endcase
`endif
   end

   // load lane select and extension
   always_comb begin
      ld_b = 8'(word >> {off, 3'b000});
      ld_h = off[1] ? word[31:16] : word[15:0];
      case (op_f3)
         3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
         3'b010:  ld_data = word;
         3'b100:  ld_data = {24'd0, ld_b};
         3'b101:  ld_data = {16'd0, ld_h};
         default: ld_data = 32'd0;
      endcase
   end

   // store byte-lane mask with data replicated across lanes
   always_comb begin
      st_mask = 4'b0000;
      st_data = op_wdata;
      case (op_f3)
         3'b000: begin
            st_mask = 4'b0001 << off;
            st_data = {4{op_wdata[7:0]}};
         end
         3'b001: begin
            st_mask = off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{op_wdata[15:0]}};
         end
         3'b010:  st_mask = 4'b1111;
         default: st_mask = 4'b0000;
      endcase
   end

   // rst gate: a zero-wait accept must not write while reset is held
   always_ff @(posedge clk) begin
      if (rst && commit && op_we && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (st_mask[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_dmem_ctrl -- bench for rv32i_dmem_ctrl.
// Three instances:
//   dut0  DEPTH 1024, WAIT 1
//   dut1  DEPTH 16,   WAIT 0
//   dut2  DEPTH 64,   WAIT 3
// A behavioural model (byte-addressed arithmetic over a word array plus a
// per-instance cycle count since acceptance) predicts busy/done/rdata/err.
// One process compares every cycle.
// Directed accesses pin the model with literal expectations.
// Randomized accesses follow.
// ---------------------------------------------------------------------------
module tb_rv32i_dmem_ctrl;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_a   [N];
   logic        we_a    [N];
   logic [31:0] addr_a  [N];
   logic [31:0] wdata_a [N];
   logic [2:0]  f3_a    [N];
   logic        busy_a  [N];
   logic        done_a  [N];
   logic [31:0] rdata_a [N];
   logic        err_a   [N];

   rv32i_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut0 (
      .clk(clk), .rst(rst), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
      .wdata(wdata_a[0]), .funct3(f3_a[0]), .busy(busy_a[0]), .done(done_a[0]),
      .rdata(rdata_a[0]), .err(err_a[0]));
   rv32i_dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
      .wdata(wdata_a[1]), .funct3(f3_a[1]), .busy(busy_a[1]), .done(done_a[1]),
      .rdata(rdata_a[1]), .err(err_a[1]));
   rv32i_dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_dut2 (
      .clk(clk), .rst(rst), .req(req_a[2]), .we(we_a[2]), .addr(addr_a[2]),
      .wdata(wdata_a[2]), .funct3(f3_a[2]), .busy(busy_a[2]), .done(done_a[2]),
      .rdata(rdata_a[2]), .err(err_a[2]));

   function automatic int dep(int d);
      case (d)
         0:       return 1024;
         1:       return 16;
         default: return 64;
      endcase
   endfunction

   function automatic int wc(int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   int errors = 0;
   int checks = 0;

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mm    [N][1024];
   int          phase [N];   // cycles since acceptance, 0 = idle
   bit          cwe   [N];
   logic [31:0] caddr [N];
   logic [31:0] cwd   [N];
   logic [2:0]  cf3   [N];
   logic [31:0] xrd   [N];
   bit          xer   [N];

   function automatic void model_access(int d, bit w, logic [31:0] a, logic [31:0] wd,
                                        logic [2:0] f3, output logic [31:0] rd, output bit er);
      int          idx, off;
      bit          ok, mis;
      logic [31:0] word;
      logic [7:0]  b;
      logic [15:0] h;
      idx = int'(a[31:2]) % dep(d);
      ok  = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
      off = int'(a[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
      if (mis) ok = 1'b0;
`else
      if (mis) off = (f3[1:0] == 2'd1) ? (off & 2) : 0;
`endif
      rd = 32'd0;
      er = !ok;
      if (!ok) return;
      word = mm[d][idx];
      if (w) begin
         case (f3[1:0])
            2'd0:    word = (word & ~(32'h0000_00FF << (8*off))) | ({24'd0, wd[7:0]}  << (8*off));
            2'd1:    word = (word & ~(32'h0000_FFFF << (8*off))) | ({16'd0, wd[15:0]} << (8*off));
            default: word = wd;
         endcase
         mm[d][idx] = word;
      end else begin
         b = 8'(word >> (8*off));
         h = 16'(word >> (8*off));
         case (f3)
            3'd0:    rd = {{24{b[7]}}, b};
            3'd1:    rd = {{16{h[15]}}, h};
            3'd2:    rd = word;
            3'd4:    rd = {24'd0, b};
            default: rd = {16'd0, h};
         endcase
      end
   endfunction

   // model advance + compare, once per edge (and at once on reset assertion)
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < N; d++) begin
            phase[d] = 0;
            xrd[d]   = 32'd0;
            xer[d]   = 1'b0;
         end
      end else begin
         for (int d = 0; d < N; d++) begin
            if (phase[d] == wc(d) + 1) phase[d] = 0;
            else if (phase[d] > 0)     phase[d]++;
            else if (req_a[d]) begin
               phase[d] = 1;
               cwe[d]   = we_a[d];
               caddr[d] = addr_a[d];
               cwd[d]   = wdata_a[d];
               cf3[d]   = f3_a[d];
            end
            if (phase[d] == wc(d) + 1)
               model_access(d, cwe[d], caddr[d], cwd[d], cf3[d], xrd[d], xer[d]);
         end
      end
      #1;
      for (int d = 0; d < N; d++) begin
         chk("busy",  d, 32'(busy_a[d]), 32'(phase[d] != 0));
         chk("done",  d, 32'(done_a[d]), 32'(phase[d] == wc(d) + 1));
         chk("rdata", d, rdata_a[d], xrd[d]);
         chk("err",   d, 32'(err_a[d]), 32'(xer[d]));
      end
   end

   // ---------------- driver ----------------
   task automatic access(int d, bit w, logic [31:0] a, logic [31:0] wd, logic [2:0] f3,
                         bit scr, bit hold, output logic [31:0] rd, output bit er, output int lat);
      int n;
      rd  = 32'd0;
      er  = 1'b0;
      lat = 0;
      @(negedge clk);
      we_a[d] = w; addr_a[d] = a; wdata_a[d] = wd; f3_a[d] = f3; req_a[d] = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (phase[d] != 1 && n < 50);
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout dut%0d: no acceptance within 50 cycles", d);
         req_a[d] = 1'b0;
         return;
      end
      lat = 1;
      while (done_a[d] !== 1'b1 && lat < 50) begin
         @(negedge clk);
         if (scr) begin
            we_a[d] = 1'($urandom_range(0, 1)); addr_a[d] = $urandom;
            wdata_a[d] = $urandom; f3_a[d] = 3'($urandom_range(0, 7));
         end
         @(posedge clk); #2; lat++;
      end
      if (lat >= 50) begin
         checks++; errors++;
         $display("FAIL done_timeout dut%0d: no done within 50 cycles", d);
      end
      rd = rdata_a[d];
      er = err_a[d];
      if (hold) @(posedge clk);   // keep req high across the RESP edge
      @(negedge clk);
      req_a[d] = 1'b0;
   endtask

   task automatic run_random(int d, int n);
      logic [31:0] rd;
      bit          er;
      int          lat;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         access(d, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, er, lat);
         chk("rand_latency", d, 32'(lat), 32'(wc(d) + 1));
      end
   endtask

   task automatic fill(int d);
      logic [31:0] rd;
      bit          er;
      int          lat;
      for (int i = 0; i < dep(d); i++)
         access(d, 1'b1, 32'(i * 4), $urandom, 3'b010, 1'b0, 1'b0, rd, er, lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lat, n;
      for (int d = 0; d < N; d++) begin
         req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = 32'd0; wdata_a[d] = 32'd0; f3_a[d] = 3'd0;
         phase[d] = 0; xrd[d] = 32'd0; xer[d] = 1'b0;
      end
      #1 rst = 1'b0;
      #20 rst = 1'b1;

      fork
         fill(0);
         fill(1);
         fill(2);
      join

      // word store/load, W=1
      access(0, 1'b1, 32'h10, 32'h8000_00FF, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("sw_latency", 0, 32'(lat), 32'd2);
      chk("sw_err", 0, 32'(er), 32'd0);
      access(0, 1'b0, 32'h10, 32'd0, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("lw_latency", 0, 32'(lat), 32'd2);
      chk("lw_data", 0, rd, 32'h8000_00FF);
      chk("lw_err", 0, 32'(er), 32'd0);

      // byte store into a known word, then signed/unsigned/word reads
      access(0, 1'b1, 32'h10, 32'h1122_3344, 3'b010, 1'b0, 1'b0, rd, er, lat);
      access(0, 1'b1, 32'h13, 32'h1234_56AB, 3'b000, 1'b0, 1'b0, rd, er, lat);
      access(0, 1'b0, 32'h13, 32'd0, 3'b000, 1'b0, 1'b0, rd, er, lat);
      chk("lb_data", 0, rd, 32'hFFFF_FFAB);
      access(0, 1'b0, 32'h13, 32'd0, 3'b100, 1'b0, 1'b0, rd, er, lat);
      chk("lbu_data", 0, rd, 32'h0000_00AB);
      access(0, 1'b0, 32'h10, 32'd0, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("lw_after_sb", 0, rd, 32'hAB22_3344);

      // misaligned halfword load
      access(0, 1'b1, 32'h10, 32'h1234_F00D, 3'b010, 1'b0, 1'b0, rd, er, lat);
      access(0, 1'b0, 32'h11, 32'd0, 3'b001, 1'b0, 1'b0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("lh_mis_data", 0, rd, 32'd0);
      chk("lh_mis_err", 0, 32'(er), 32'd1);
`else
      chk("lh_mis_data", 0, rd, 32'hFFFF_F00D);
      chk("lh_mis_err", 0, 32'(er), 32'd0);
`endif

      // illegal codes: no update, err=1, rdata=0
      access(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b011, 1'b0, 1'b0, rd, er, lat);
      chk("bad_store_err", 0, 32'(er), 32'd1);
      access(0, 1'b0, 32'h10, 32'd0, 3'b110, 1'b0, 1'b0, rd, er, lat);
      chk("bad_load_err", 0, 32'(er), 32'd1);
      chk("bad_load_data", 0, rd, 32'd0);
      access(0, 1'b0, 32'h10, 32'd0, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("no_update", 0, rd, 32'h1234_F00D);

      // zero wait states, address wrap in a 16-word memory
      access(1, 1'b1, 32'h40, 32'h5A5A_5A5A, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("w0_sw_latency", 1, 32'(lat), 32'd1);
      access(1, 1'b0, 32'h00, 32'd0, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("w0_wrap_data", 1, rd, 32'h5A5A_5A5A);
      chk("w0_lw_latency", 1, 32'(lat), 32'd1);

      // reset during WAIT discards the pending store
      access(2, 1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0, rd, er, lat);
      chk("w3_latency", 2, 32'(lat), 32'd4);
      @(negedge clk);
      we_a[2] = 1'b1; addr_a[2] = 32'h20; wdata_a[2] = 32'h0BAD_F00D; f3_a[2] = 3'b010; req_a[2] = 1'b1;
      @(posedge clk); #2;
      chk("rst_pre_busy", 2, 32'(busy_a[2]), 32'd1);
      @(negedge clk); #1 rst = 1'b0;
      #1;
      chk("rst_busy", 2, 32'(busy_a[2]), 32'd0);
      chk("rst_done", 2, 32'(done_a[2]), 32'd0);
      we_a[2] = 1'b0; addr_a[2] = 32'h20; f3_a[2] = 3'b010;
      @(negedge clk); #1 rst = 1'b1;
      @(posedge clk); #2;
      chk("post_rst_accept", 2, 32'(busy_a[2]), 32'd1);
      n = 0;
      while (done_a[2] !== 1'b1 && n < 50) begin @(posedge clk); #2; n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL post_rst_done dut2: no done within 50 cycles");
      end
      chk("rst_old_data", 2, rdata_a[2], 32'hDEAD_BEEF);
      @(negedge clk);
      req_a[2] = 1'b0;

      fork
         run_random(0, 300);
         run_random(1, 300);
         run_random(2, 300);
      join

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv32i_dmem_ctrl.md
RV32I_DMEM_CTRL -- requirements
Module: rv32i_dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, sets memory depth in 32-bit words; the value SHALL be a power of two, from 16 to 65536.
REQ-002 Parameter WAIT_CYCLES, default 1, sets the wait states inserted per access; the value SHALL be an integer from 0 to 15.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req  input  1  access request; the requester SHALL hold it with stable payload until done.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, taken from the low-order bytes.
REQ-009 funct3  input  3  RV32I width/sign code.
REQ-010 busy  output  1  high while an access is in flight.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  load result, valid while done=1.
REQ-013 err  output  1  error flag, valid while done=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL capture we, addr, wdata and funct3, load the wait counter with WAIT_CYCLES, and move to WAIT (or directly to RESP when WAIT_CYCLES=0).
REQ-016 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches 0, the block SHALL commit the write or register the read data and enter RESP.
REQ-017 In RESP, done SHALL be 1 for exactly one cycle, followed by a return to IDLE; a req seen in RESP SHALL NOT be accepted.
REQ-018 Accept-to-done latency SHALL be WAIT_CYCLES+1 cycles; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-019 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap modulo the memory size.
REQ-021 Loads: 000 LB and 001 LH SHALL sign-extend; 010 LW returns the full word; 100 LBU and 101 LHU SHALL zero-extend; the byte/halfword lane is selected by addr[1:0].
REQ-022 Stores: 000 SB, 001 SH and 010 SW SHALL update only the addressed byte lanes; all other lanes SHALL be preserved.
REQ-023 Any other funct3 (store 011-111; load 011, 110, 111) SHALL cause err=1, rdata=0 and no memory update.
REQ-024 done SHALL be 0 outside RESP; rdata and err SHALL hold their last values between accesses.
REQ-025 Changes to the payload after acceptance SHALL NOT affect the access in flight.

Reset
REQ-026 When rst goes low, the block SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, err=0 and rdata=0.
REQ-027 A reset during WAIT SHALL discard the pending access, so no write is committed.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 After reset release, the first req SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL complete with err=1, rdata=0 and no memory update, using normal latency.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, the block SHALL force addr[0]=0 for halfword accesses and addr[1:0]=0 for word accesses, completing each with err=0.

Verification
REQ-032 With WAIT_CYCLES=1: SW 0x8000_00FF at addr 0x10, then LW at 0x10 -> done 2 cycles after each accept; rdata=0x8000_00FF; err=0.
REQ-033 SB 0xAB at addr 0x13 over word 0x1122_3344, then LB at 0x13 -> rdata=0xFFFF_FFAB; LBU at 0x13 -> 0x0000_00AB; LW at 0x10 -> 0xAB22_3344.
REQ-034 With WAIT_CYCLES=0 and DEPTH_WORDS=16: SW 0x5A5A_5A5A at addr 0x40, then LW at 0x00 -> rdata=0x5A5A_5A5A (wrap), with done 1 cycle after accept.
REQ-035 LH at addr 0x11 with the macro defined -> err=1, rdata=0; without the macro -> rdata equals the sign-extended halfword at 0x10, err=0.
REQ-036 With WAIT_CYCLES=3: SW accepted, then rst driven low during WAIT, then released, then LW at the same address -> the old data is returned, and busy/done read 0 immediately on rst assertion.
